// File: rtl/spi_xfer_ctrl.sv
// Transaction sequencer for the SPI latch datapath: takes one transfer descriptor per start,
// generates ss_n/sclk and the datapath strobes through SETUP/LOAD/TX/DUMMY/RX/HOLD/DONE.
module spi_xfer_ctrl #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] clk_div,
   input  logic [7:0]       tx_bits,
   input  logic [1:0]       tx_mode,
   input  logic [3:0]       dummy_cycles,
   input  logic [6:0]       rx_bits,
   input  logic [1:0]       rx_mode,
   output logic             busy,
   output logic             done,
   output logic             ss_n,
   output logic             sclk,
   output logic             sclk_en,
   output logic             setup_rst,
   output logic             loadtxdata_en,
   output logic             latchout_en,
   output logic             latchin_en,
   output logic [7:0]       mosistop_cnt,
   output logic [6:0]       misostop_cnt,
   output logic             dualtx_en,
   output logic             quadtx_en,
   output logic             dualrx,
   output logic             quadrx
);

   typedef enum logic [2:0] {IDLE, SETUP, LOAD, TX, DUMMY, RX, HOLD, DONE} state_t;

   state_t           state;
   state_t           phase_next;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_cnt;
   logic [7:0]       rises;
   logic [7:0]       phase_target;
   logic [7:0]       tx_beats_q;
   logic [6:0]       rx_beats_q;
   logic [3:0]       dummy_q;
   logic [6:0]       rx_step;
   logic             tc;

   // Lane width -> shift amount: dual moves 2 bits per beat, quad 4, everything else 1.
   function automatic logic [1:0] mode_shift(input logic [1:0] mode);
      case (mode)
         2'b01:   return 2'd1;
         2'b10:   return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   assign rx_step = 7'd1 << mode_shift(rx_mode);
   assign tc      = (div_cnt == div_q - DIV_W'(1));

   // Successor of the current state among the SCLK phases, skipping empty ones.
   always_comb begin
      phase_next = HOLD;
      case (state)
         LOAD: begin
            if (tx_beats_q != '0)        phase_next = TX;
            else if (dummy_q != '0)      phase_next = DUMMY;
            else if (rx_beats_q != '0)   phase_next = RX;
         end
         TX: begin
            if (dummy_q != '0)           phase_next = DUMMY;
            else if (rx_beats_q != '0)   phase_next = RX;
         end
         DUMMY: begin
            if (rx_beats_q != '0)        phase_next = RX;
         end
         default: phase_next = HOLD;
      endcase
   end

   always_comb begin
      phase_target = '0;
      case (state)
         TX:      phase_target = tx_beats_q;
         DUMMY:   phase_target = {4'd0, dummy_q};
         RX:      phase_target = {1'b0, rx_beats_q};
         default: phase_target = '0;
      endcase
   end

   // NOTE: every register here uses <= so all state updates in a cycle see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         ss_n          <= 1'b1;
         sclk          <= 1'b0;
         sclk_en       <= 1'b0;
         setup_rst     <= 1'b0;
         loadtxdata_en <= 1'b0;
         latchout_en   <= 1'b0;
         latchin_en    <= 1'b0;
         mosistop_cnt  <= '0;
         misostop_cnt  <= '0;
         dualtx_en     <= 1'b0;
         quadtx_en     <= 1'b0;
         dualrx        <= 1'b0;
         quadrx        <= 1'b0;
         div_q         <= '0;
         div_cnt       <= '0;
         rises         <= '0;
         tx_beats_q    <= '0;
         rx_beats_q    <= '0;
         dummy_q       <= '0;
      end else begin
         setup_rst     <= 1'b0;
         loadtxdata_en <= 1'b0;
         latchout_en   <= 1'b0;
         latchin_en    <= 1'b0;
         done          <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start && !busy) begin
                  mosistop_cnt <= tx_bits;
                  misostop_cnt <= (rx_bits < rx_step) ? 7'd0 : rx_bits - rx_step;
                  dualtx_en    <= (tx_mode == 2'b01);
                  quadtx_en    <= (tx_mode == 2'b10);
                  dualrx       <= (rx_mode == 2'b01);
                  quadrx       <= (rx_mode == 2'b10);
                  tx_beats_q   <= tx_bits >> mode_shift(tx_mode);
                  rx_beats_q   <= rx_bits >> mode_shift(rx_mode);
                  dummy_q      <= dummy_cycles;
                  div_q        <= (clk_div == '0) ? DIV_W'(1) : clk_div;
                  ss_n         <= 1'b0;
                  busy         <= 1'b1;
                  setup_rst    <= 1'b1;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               loadtxdata_en <= 1'b1;
               latchout_en   <= (tx_beats_q != '0);
               state         <= LOAD;
            end
            LOAD: begin
               div_cnt <= '0;
               rises   <= '0;
               sclk_en <= (phase_next != HOLD);
               state   <= phase_next;
            end
            TX, DUMMY, RX: begin
               if (tc) begin
                  div_cnt <= '0;
                  if (!sclk) begin
                     sclk       <= 1'b1;
                     latchin_en <= 1'b1;
                     rises      <= rises + 8'd1;
                  end else begin
                     sclk        <= 1'b0;
                     latchout_en <= 1'b1;
                     // The phase ends on the fall that follows its last counted rise.
                     if (rises == phase_target) begin
                        rises   <= '0;
                        sclk_en <= (phase_next != HOLD);
                        state   <= phase_next;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            HOLD: begin
               if (tc) begin
                  div_cnt <= '0;
                  ss_n    <= 1'b1;
                  state   <= DONE;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: background edge/pulse counters plus a linear
// sequence of transfers with hand-computed expected counts.
module tb_spi_xfer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] clk_div;
   logic [7:0] tx_bits;
   logic [1:0] tx_mode;
   logic [3:0] dummy_cycles;
   logic [6:0] rx_bits;
   logic [1:0] rx_mode;
   logic       busy, done, ss_n, sclk, sclk_en, setup_rst, loadtxdata_en;
   logic       latchout_en, latchin_en;
   logic [7:0] mosistop_cnt;
   logic [6:0] misostop_cnt;
   logic       dualtx_en, quadtx_en, dualrx, quadrx;

   int total = 0;
   int bad   = 0;

   spi_xfer_ctrl #(.DIV_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .clk_div(clk_div),
      .tx_bits(tx_bits), .tx_mode(tx_mode), .dummy_cycles(dummy_cycles),
      .rx_bits(rx_bits), .rx_mode(rx_mode),
      .busy(busy), .done(done), .ss_n(ss_n), .sclk(sclk), .sclk_en(sclk_en),
      .setup_rst(setup_rst), .loadtxdata_en(loadtxdata_en),
      .latchout_en(latchout_en), .latchin_en(latchin_en),
      .mosistop_cnt(mosistop_cnt), .misostop_cnt(misostop_cnt),
      .dualtx_en(dualtx_en), .quadtx_en(quadtx_en), .dualrx(dualrx), .quadrx(quadrx)
   );

   always #5 clk = ~clk;

   // Free-running monitors sampled mid-cycle; tests compare deltas against snapshots.
   int   cyc = 0, n_rise = 0, n_lo = 0, n_li = 0, n_setup = 0, n_load = 0, n_done = 0, n_en = 0;
   int   last_rise = 0, period = 0, hi_run = 0, last_hi = 0, ssn_rise = 0, done_at = 0;
   logic sclk_d = 1'b0, ssn_d = 1'b1;

   always @(negedge clk) begin
      cyc    <= cyc + 1;
      sclk_d <= sclk;
      ssn_d  <= ss_n;
      if (sclk && !sclk_d) begin
         n_rise    <= n_rise + 1;
         period    <= cyc - last_rise;
         last_rise <= cyc;
      end
      if (sclk) hi_run <= hi_run + 1;
      else begin
         if (sclk_d) last_hi <= hi_run;
         hi_run <= 0;
      end
      if (ss_n && !ssn_d) ssn_rise <= cyc;
      if (done) begin
         n_done  <= n_done + 1;
         done_at <= cyc;
      end
      if (latchout_en)   n_lo    <= n_lo + 1;
      if (latchin_en)    n_li    <= n_li + 1;
      if (setup_rst)     n_setup <= n_setup + 1;
      if (loadtxdata_en) n_load  <= n_load + 1;
      if (sclk_en)       n_en    <= n_en + 1;
   end

   int s_rise, s_lo, s_li, s_setup, s_load, s_done, s_en;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_rise = n_rise; s_lo = n_lo; s_li = n_li; s_setup = n_setup;
      s_load = n_load; s_done = n_done; s_en = n_en;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic launch(input logic [7:0] div, input logic [7:0] txb, input logic [1:0] txm,
                         input logic [3:0] dm, input logic [6:0] rxb, input logic [1:0] rxm);
      @(negedge clk);
      clk_div = div; tx_bits = txb; tx_mode = txm;
      dummy_cycles = dm; rx_bits = rxb; rx_mode = rxm;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; clk_div = '0; tx_bits = '0; tx_mode = '0;
      dummy_cycles = '0; rx_bits = '0; rx_mode = '0;
      settle(3);
      check("rst_ss_n", ss_n, 1);
      check("rst_busy", busy, 0);
      check("rst_sclk", sclk, 0);
      check("rst_done", done, 0);
      check("rst_strobes", {setup_rst, loadtxdata_en, latchout_en, latchin_en, sclk_en}, 0);
      check("rst_counts", {mosistop_cnt, misostop_cnt}, 0);
      check("rst_modes", {dualtx_en, quadtx_en, dualrx, quadrx}, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: 8 single-lane TX beats at clk_div=2.
      snap();
      launch(8'd2, 8'd8, 2'b00, 4'd0, 7'd0, 2'b00);
      check("t1_busy", busy, 1);
      check("t1_ss_n_low", ss_n, 0);
      wait_done("t1_done_seen");
      // start during the done cycle must be ignored
      tx_bits = 8'd16;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      settle(4);
      check("t1_start_in_done_ignored", busy, 0);
      check("t1_mosistop", mosistop_cnt, 8);
      check("t1_misostop", misostop_cnt, 0);
      check("t1_rises", n_rise - s_rise, 8);
      check("t1_latchout", n_lo - s_lo, 9);
      check("t1_latchin", n_li - s_li, 8);
      check("t1_period", period, 4);
      check("t1_done_after_ss_n", done_at - ssn_rise, 1);
      check("t1_setup_load", {n_setup - s_setup, n_load - s_load}, {32'd1, 32'd1});
      check("t1_done_count", n_done - s_done, 1);

      // 2: quad read with dummy cycles.
      snap();
      launch(8'd1, 8'd32, 2'b10, 4'd6, 7'd32, 2'b10);
      wait_done("t2_done_seen");
      settle(3);
      check("t2_rises", n_rise - s_rise, 22);
      check("t2_latchin", n_li - s_li, 22);
      check("t2_latchout", n_lo - s_lo, 23);
      check("t2_misostop", misostop_cnt, 28);
      check("t2_mosistop", mosistop_cnt, 32);
      check("t2_modes", {dualtx_en, quadtx_en, dualrx, quadrx}, 4'b0101);
      check("t2_period", period, 2);

      // 3: second start mid-TX is dropped.
      snap();
      launch(8'd2, 8'd16, 2'b00, 4'd0, 7'd0, 2'b00);
      settle(10);
      tx_bits = 8'd40; tx_mode = 2'b01; rx_bits = 7'd20;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("t3_busy_mid", busy, 1);
      check("t3_desc_held", {mosistop_cnt, dualtx_en}, {8'd16, 1'b0});
      wait_done("t3_done_seen");
      settle(30);
      check("t3_one_done", n_done - s_done, 1);
      check("t3_rises", n_rise - s_rise, 16);
      check("t3_idle", busy, 0);

      // 4: reset in the middle of RX, then a clean transfer.
      snap();
      launch(8'd2, 8'd8, 2'b00, 4'd0, 7'd16, 2'b01);
      begin
         int n = 0;
         while ((n_rise - s_rise) < 11 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
         end
         check("t4_reached_rx", (n_rise - s_rise) >= 11, 1);
      end
      #1 rst = 1'b1;
      #1;
      check("t4_rst_ss_n", ss_n, 1);
      check("t4_rst_sclk", sclk, 0);
      check("t4_rst_busy", busy, 0);
      check("t4_rst_strobes", {setup_rst, loadtxdata_en, latchout_en, latchin_en, sclk_en, done}, 0);
      check("t4_rst_desc", {mosistop_cnt, misostop_cnt, dualrx}, 0);
      settle(2);
      @(negedge clk);
      rst = 1'b0;
      snap();
      launch(8'd1, 8'd8, 2'b00, 4'd0, 7'd8, 2'b00);
      wait_done("t4_clean_done_seen");
      settle(3);
      check("t4_clean_rises", n_rise - s_rise, 16);
      check("t4_clean_misostop", misostop_cnt, 7);
      check("t4_clean_done_count", n_done - s_done, 1);

      // 5: clk_div=0 acts as 1; 3 dual bits give one beat.
      snap();
      launch(8'd0, 8'd3, 2'b01, 4'd0, 7'd0, 2'b00);
      wait_done("t5_done_seen");
      settle(3);
      check("t5_rises", n_rise - s_rise, 1);
      check("t5_latchout", n_lo - s_lo, 2);
      check("t5_latchin", n_li - s_li, 1);
      check("t5_high_time", last_hi, 1);
      check("t5_desc", {mosistop_cnt, dualtx_en}, {8'd3, 1'b1});

      // 6: empty descriptor still sequences SETUP/LOAD/HOLD/DONE.
      snap();
      launch(8'd3, 8'd0, 2'b00, 4'd0, 7'd0, 2'b00);
      wait_done("t6_done_seen");
      settle(3);
      check("t6_setup", n_setup - s_setup, 1);
      check("t6_load", n_load - s_load, 1);
      check("t6_done", n_done - s_done, 1);
      check("t6_no_rises", n_rise - s_rise, 0);
      check("t6_no_latchout", n_lo - s_lo, 0);
      check("t6_no_sclk_en", n_en - s_en, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
